// File: rtl/trace_dispatch_queue_if.sv
// Handshake bundle between the trace record source, the dispatch queue and the cache.
// The queue uses the slave view; the producer/consumer side uses the master view.
interface trace_dispatch_queue_if #(
    parameter int ADDRESS_BITS = 32,
    parameter int OFFSET_BITS  = 6,
    parameter int INDEX_BITS   = 4
);
    localparam int TAG_BITS = ADDRESS_BITS - OFFSET_BITS - INDEX_BITS;

    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_cmd;
    logic [ADDRESS_BITS-1:0] in_addr;

    logic                    out_valid;
    logic                    out_ready;
    logic [2:0]              out_cmd;
    logic [TAG_BITS-1:0]     out_tag;
    logic [INDEX_BITS-1:0]   out_index;
    logic [OFFSET_BITS-1:0]  out_offset;
    logic                    out_icache;
    logic                    out_bcast;

    modport slave (
        input  in_valid, in_cmd, in_addr, out_ready,
        output in_ready, out_valid, out_cmd, out_tag, out_index, out_offset,
               out_icache, out_bcast
    );

    modport master (
        output in_valid, in_cmd, in_addr, out_ready,
        input  in_ready, out_valid, out_cmd, out_tag, out_index, out_offset,
               out_icache, out_bcast
    );
endinterface

// File: rtl/trace_dispatch_queue.sv
// In-order FIFO of trace records feeding the caches; CLR/PRINT wait until the
// cache reports idle before being presented. Illegal commands are counted and dropped.
module trace_dispatch_queue #(
    parameter int ADDRESS_BITS = 32,
    parameter int OFFSET_BITS  = 6,
    parameter int INDEX_BITS   = 4,
    parameter int DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    trace_dispatch_queue_if.slave    bus,
    input  logic                     cache_busy,
    output logic                     err_cmd,
    output logic [15:0]              drop_count,
    output logic [31:0]              rec_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    localparam logic [2:0] CMD_IFETCH   = 3'd2;
    localparam logic [2:0] CMD_L2_INVAL = 3'd3;
    localparam logic [2:0] CMD_L2_DATA  = 3'd4;
    localparam logic [2:0] CMD_CLR      = 3'd5;
    localparam logic [2:0] CMD_PRINT    = 3'd6;
    localparam logic [2:0] CMD_ILLEGAL  = 3'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cmd_mem  [DEPTH];
    logic [ADDRESS_BITS-1:0] addr_mem [DEPTH];
    logic [PTR_BITS-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]       count_q, count_d;
    logic                    busy_q, err_q;
    logic [15:0]             drop_q, drop_d;
    logic [31:0]             rec_q, rec_d;

    logic                    accept, illegal, push, pop;
    logic [2:0]              head_cmd, next_head_cmd;
    logic [ADDRESS_BITS-1:0] head_addr;

    function automatic logic serializing(input logic [2:0] cmd);
        return (cmd == CMD_CLR) || (cmd == CMD_PRINT);
    endfunction

    // A serializing head must not reach the cache while it is still busy.
    function automatic state_t dispatch_state(input logic [2:0] cmd, input logic busy);
        return (serializing(cmd) && busy) ? DRAIN : ISSUE;
    endfunction

    assign bus.in_ready = (count_q < FULL_COUNT);
    assign accept       = bus.in_valid && bus.in_ready;
    assign illegal      = accept && (bus.in_cmd == CMD_ILLEGAL);
    assign push         = accept && !illegal;
    assign pop          = bus.out_valid && bus.out_ready;
    assign head_cmd     = cmd_mem[rd_ptr_q];
    assign head_addr    = addr_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_BITS'(push);
        rd_ptr_d = rd_ptr_q + PTR_BITS'(pop);
        count_d  = count_q + (PTR_BITS+1)'(push) - (PTR_BITS+1)'(pop);
        drop_d   = (illegal && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
        rec_d    = pop ? rec_q + 32'd1 : rec_q;
        // The head after this edge may be the record being written right now.
        next_head_cmd = (push && (wr_ptr_q == rd_ptr_d)) ? bus.in_cmd : cmd_mem[rd_ptr_d];
    end

    always_comb begin
        state_d = state_q;
        if (count_d == '0) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = dispatch_state(next_head_cmd, cache_busy);
                ISSUE:   if (pop) state_d = dispatch_state(next_head_cmd, cache_busy);
                DRAIN:   if (!busy_q) state_d = ISSUE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            drop_q   <= '0;
            rec_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= cache_busy;
            err_q    <= illegal;
            drop_q   <= drop_d;
            rec_q    <= rec_d;
        end
    end

    // Record storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr_q]  <= bus.in_cmd;
            addr_mem[wr_ptr_q] <= bus.in_addr;
        end
    end

    assign bus.out_valid = (state_q == ISSUE);

    always_comb begin
        bus.out_cmd    = '0;
        bus.out_tag    = '0;
        bus.out_index  = '0;
        bus.out_offset = '0;
        bus.out_icache = 1'b0;
        bus.out_bcast  = 1'b0;
        if (bus.out_valid) begin
            bus.out_cmd    = head_cmd;
            bus.out_icache = (head_cmd == CMD_IFETCH);
            bus.out_bcast  = (head_cmd == CMD_L2_INVAL) || (head_cmd == CMD_L2_DATA) ||
                             serializing(head_cmd);
            if (!serializing(head_cmd)) begin
                bus.out_tag    = head_addr[ADDRESS_BITS-1:OFFSET_BITS+INDEX_BITS];
                bus.out_index  = head_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
                bus.out_offset = head_addr[OFFSET_BITS-1:0];
            end
        end
    end

    assign err_cmd    = err_q;
    assign drop_count = drop_q;
    assign rec_count  = rec_q;
    assign level      = count_q;
endmodule

// File: tb/tb_trace_dispatch_queue.sv
// Randomized and directed bench for trace_dispatch_queue against a queue-based reference model.
module tb_trace_dispatch_queue;
    localparam int AB    = 32;
    localparam int OB    = 6;
    localparam int IB    = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [AB-1:0] addr;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cache_busy = 1'b0;
    logic          err_cmd;
    logic [15:0]   drop_count;
    logic [31:0]   rec_count;
    logic [LW-1:0] level;

    trace_dispatch_queue_if #(.ADDRESS_BITS(AB), .OFFSET_BITS(OB), .INDEX_BITS(IB)) bus ();

    trace_dispatch_queue #(
        .ADDRESS_BITS(AB), .OFFSET_BITS(OB), .INDEX_BITS(IB), .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cache_busy (cache_busy),
        .err_cmd    (err_cmd),
        .drop_count (drop_count),
        .rec_count  (rec_count),
        .level      (level)
    );

    always #5 clk = ~clk;

    rec_t        q[$];
    longint      m_drop, m_rec;
    bit          m_err;
    bit          strict;
    int          checks, failures;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_ser(input logic [2:0] c);
        return (c == 3'd5) || (c == 3'd6);
    endfunction

    task automatic check_head();
        rec_t r;
        longint unsigned a;
        r = q[0];
        a = longint'(r.addr);
        check_eq("head_cmd", bus.out_cmd, r.cmd);
        check_eq("head_tag", bus.out_tag, is_ser(r.cmd) ? 0 : a / (2 ** (OB + IB)));
        check_eq("head_index", bus.out_index, is_ser(r.cmd) ? 0 : (a / (2 ** OB)) % (2 ** IB));
        check_eq("head_offset", bus.out_offset, is_ser(r.cmd) ? 0 : a % (2 ** OB));
        check_eq("head_icache", bus.out_icache, r.cmd == 3'd2);
        check_eq("head_bcast", bus.out_bcast, r.cmd >= 3'd3 && r.cmd <= 3'd6);
    endtask

    task automatic check_model();
        check_eq("level", level, q.size());
        check_eq("in_ready", bus.in_ready, q.size() < DEPTH);
        check_eq("drop_count", drop_count, m_drop);
        check_eq("rec_count", rec_count, m_rec);
        check_eq("err_cmd", err_cmd, m_err);
        if (strict) check_eq("out_valid", bus.out_valid, q.size() != 0);
        else if (q.size() == 0) check_eq("out_valid_empty", bus.out_valid, 0);
        else if (!is_ser(q[0].cmd)) check_eq("out_valid_nonser", bus.out_valid, 1);
        if (bus.out_valid && q.size() != 0) check_head();
    endtask

    // Called at a falling edge: drive, take one rising edge, update the model, check.
    task automatic step(input bit iv, input logic [2:0] ic, input logic [AB-1:0] ia,
                        input bit ordy, input bit busy);
        bit   acc, pop;
        rec_t r;
        bus.in_valid  = iv;
        bus.in_cmd    = ic;
        bus.in_addr   = ia;
        bus.out_ready = ordy;
        cache_busy    = busy;
        acc = iv && (q.size() < DEPTH);
        pop = bus.out_valid && ordy;
        @(posedge clk);
        m_err = 1'b0;
        if (pop && q.size() != 0) begin
            void'(q.pop_front());
            m_rec = (m_rec + 1) % (64'd1 << 32);
        end
        if (acc) begin
            if (ic == 3'd7) begin
                m_err = 1'b1;
                if (m_drop < 16'hFFFF) m_drop++;
            end else begin
                r.cmd  = ic;
                r.addr = ia;
                q.push_back(r);
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) step(1'b0, 3'd0, '0, 1'b1, 1'b0);
        step(1'b0, 3'd0, '0, 1'b1, 1'b0);
        check_eq("drain_empty", q.size(), 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        m_drop = 0; m_rec = 0; m_err = 0; strict = 1;
        bus.in_valid = 0; bus.in_cmd = 0; bus.in_addr = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);

        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_level", level, 0);
        check_eq("rst_err", err_cmd, 0);
        check_eq("rst_drop", drop_count, 0);
        check_eq("rst_rec", rec_count, 0);
        check_eq("rst_fields", {bus.out_cmd, bus.out_tag, bus.out_index, bus.out_offset,
                                bus.out_icache, bus.out_bcast}, 0);
        rst_n = 1'b1;

        // Single READ record decoded one cycle after the push.
        step(1'b1, 3'd0, 32'h0000_1A7F, 1'b1, 1'b0);
        check_eq("rd_valid", bus.out_valid, 1);
        check_eq("rd_cmd", bus.out_cmd, 0);
        check_eq("rd_tag", bus.out_tag, 22'h6);
        check_eq("rd_index", bus.out_index, 4'h9);
        check_eq("rd_offset", bus.out_offset, 6'h3F);
        check_eq("rd_icache", bus.out_icache, 0);
        step(1'b0, 3'd0, '0, 1'b1, 1'b0);
        check_eq("rd_rec_count", rec_count, 1);

        // Fill to capacity, attempt a ninth push, then free one slot.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 3'($urandom_range(0, 6)), $urandom, 1'b0, 1'b0);
        check_eq("full_level", level, DEPTH);
        check_eq("full_in_ready", bus.in_ready, 0);
        step(1'b1, 3'd1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_eq("full_level_9th", level, DEPTH);
        step(1'b0, 3'd0, '0, 1'b1, 1'b0);
        check_eq("pop_in_ready", bus.in_ready, 1);
        check_eq("pop_level", level, DEPTH - 1);
        drain(40);

        // Illegal command is dropped; the following I_FETCH is issued.
        step(1'b1, 3'd7, 32'h1234_5678, 1'b1, 1'b0);
        check_eq("ill_err_pulse", err_cmd, 1);
        check_eq("ill_drop", drop_count, 1);
        check_eq("ill_not_issued", bus.out_valid, 0);
        step(1'b1, 3'd2, 32'h0000_0400, 1'b1, 1'b0);
        check_eq("ill_err_clear", err_cmd, 0);
        check_eq("if_valid", bus.out_valid, 1);
        check_eq("if_cmd", bus.out_cmd, 2);
        check_eq("if_icache", bus.out_icache, 1);
        check_eq("if_tag", bus.out_tag, 22'h1);
        check_eq("if_index", bus.out_index, 0);
        drain(10);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 1'b0);
        drain(40);

        // CLR held back while the cache is busy.
        strict = 0;
        step(1'b1, 3'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'd0, '0, 1'b1, 1'b1);
            check_eq("clr_held", bus.out_valid, 0);
        end
        step(1'b0, 3'd0, '0, 1'b0, 1'b0);
        check_eq("clr_wait1", bus.out_valid, 0);
        step(1'b0, 3'd0, '0, 1'b0, 1'b0);
        check_eq("clr_valid", bus.out_valid, 1);
        check_eq("clr_bcast", bus.out_bcast, 1);
        check_eq("clr_fields", {bus.out_tag, bus.out_index, bus.out_offset}, 0);
        drain(10);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        drain(100);
        strict = 1;
        step(1'b0, 3'd0, '0, 1'b1, 1'b0);

        // Reset asserted mid-cycle with records queued and one presented.
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, $urandom, 1'b0, 1'b0);
        step(1'b0, 3'd0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", bus.out_valid, 0);
        check_eq("mid_rst_level", level, 0);
        check_eq("mid_rst_rec", rec_count, 0);
        check_eq("mid_rst_in_ready", bus.in_ready, 1);
        check_eq("mid_rst_fields", {bus.out_tag, bus.out_index, bus.out_offset}, 0);
        q.delete();
        m_rec = 0; m_drop = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd4, 32'hCAFE_0042, 1'b1, 1'b0);
        check_eq("post_rst_bcast", bus.out_bcast, 1);
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trace_dispatch_queue.md
TRACE_DISPATCH_QUEUE -- requirements
Module: trace_dispatch_queue

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 32, byte address width of trace records.
REQ-002 SHALL have parameter OFFSET_BITS, default 6, line byte-select width.
REQ-003 SHALL have parameter INDEX_BITS, default 4, set-index width shared by instruction and data caches (16 sets).
REQ-004 SHALL have parameter DEPTH, default 8, FIFO entries, power of two, minimum 2.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_cmd input 3, in_addr input ADDRESS_BITS: trace record intake.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_cmd output 3: request presented to cache.
REQ-009 SHALL have ports out_tag output ADDRESS_BITS-OFFSET_BITS-INDEX_BITS, out_index output INDEX_BITS, out_offset output OFFSET_BITS: decoded address fields.
REQ-010 SHALL have ports out_icache output 1 (I_FETCH target) and out_bcast output 1 (target both caches).
REQ-011 SHALL have port cache_busy  input  1  cache still processing a prior request.
REQ-012 SHALL have ports err_cmd output 1 (illegal-command pulse), drop_count output 16, rec_count output 32, level output $clog2(DEPTH)+1.

Function
REQ-013 SHALL use command codes READ=0, WRITE=1, I_FETCH=2, L2_INVAL=3, L2_DATA_RQ=4, CLR=5, PRINT=6; code 7 is illegal.
REQ-014 SHALL drive in_ready = 1 iff FIFO count < DEPTH; accept a record when in_valid && in_ready.
REQ-015 SHALL, for accepted code 7, not store the record, pulse err_cmd for exactly one cycle on the next cycle, increment drop_count, saturating at 0xFFFF.
REQ-016 SHALL store legal records in order; no bypass: earliest out_valid is the cycle after the push.
REQ-017 SHALL when full reject pushes even if a pop occurs in the same cycle; when not full, a simultaneous push and pop leave level unchanged.
REQ-018 SHALL run FSM IDLE (FIFO empty, out_valid=0), ISSUE (head presented, out_valid=1), DRAIN (head is CLR or PRINT and cache_busy=1, out_valid=0).
REQ-019 SHALL transition IDLE->ISSUE when a legal entry exists and head is not CLR/PRINT, or cache_busy=0; otherwise IDLE->DRAIN.
REQ-020 SHALL transition DRAIN->ISSUE in the cycle after cache_busy is sampled 0; out_valid rises one cycle later.
REQ-021 SHALL, on out_valid && out_ready, pop head, increment rec_count (wrapping), re-evaluate next head per REQ-019 without a bubble for non-serializing heads.
REQ-022 SHALL hold all out_* signals stable while out_valid=1 and out_ready=0.
REQ-023 SHALL decode out_tag = addr[ADDRESS_BITS-1:OFFSET_BITS+INDEX_BITS], out_index = addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], out_offset = addr[OFFSET_BITS-1:0].
REQ-024 SHALL set out_icache=1 only for I_FETCH; out_bcast=1 for L2_INVAL, L2_DATA_RQ, CLR, PRINT.
REQ-025 SHALL drive out_tag, out_index, out_offset to 0 for CLR and PRINT.
REQ-026 SHALL report level as current FIFO occupancy 0..DEPTH, with pointer wrap-around invisible to level.

Reset
REQ-027 SHALL, while rst_n=0, clear FIFO, pointers, counters and FSM (IDLE); out_valid=0, err_cmd=0, all out_* fields 0, drop_count=0, rec_count=0, level=0, in_ready=1.
REQ-028 SHALL discard all queued and presented records on reset assertion mid-operation, with no handshake completing in the reset cycle.

Verification
REQ-029 SHALL verify: push READ 0x00001A7F, out_ready=1 -> next cycle out_valid=1, out_cmd=0, out_tag=0x6, out_index=0x9, out_offset=0x3F, out_icache=0, rec_count=1.
REQ-030 SHALL verify: 8 pushes with out_ready=0 -> level=8, in_ready=0, 9th record not taken; one pop -> in_ready=1 next cycle, order preserved.
REQ-031 SHALL verify: push CLR with cache_busy=1 for 5 cycles -> out_valid stays 0 (DRAIN); cache_busy falls -> out_valid=1 two cycles later, out_bcast=1, fields 0.
REQ-032 SHALL verify: push cmd 7 then I_FETCH 0x00000400 -> err_cmd one-cycle pulse, drop_count=1, only I_FETCH issued with out_icache=1, out_tag=0x1, out_index=0.
REQ-033 SHALL verify: 3 queued records, out_valid held with out_ready=0, then rst_n=0 mid-cycle -> out_valid=0, level=0, rec_count=0 immediately.
